mdu_stage: RTL and testbench

- Multiply/divide unit for the CPU's execute stage.
- Sits downstream of the register-file read ports, beside the ALU; consumes `rd1`/`rd2`.
- Owns the architectural HI/LO registers and models fixed multi-cycle latency through a `busy` output.
- The control/hazard logic stalls on `busy | start` and reads HI/LO through `mdres` for MFHI/MFLO write-back.

---
 rtl/mdu_pkg.sv | 41 ++++
 rtl/mdu_stage_if.sv | 22 ++
 rtl/mdu_arith.sv | 59 +++++
 rtl/mdu_stage.sv | 116 +++++++++++
 tb/tb_mdu_stage.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Multiply/divide unit shared definitions: mdop encodings, FSM state type,
// default latencies and op-class helpers.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU accumulate ops).
package mdu_pkg;

  localparam logic [3:0] MDOP_NOP   = 4'd0;
  localparam logic [3:0] MDOP_MULT  = 4'd1;
  localparam logic [3:0] MDOP_MULTU = 4'd2;
  localparam logic [3:0] MDOP_DIV   = 4'd3;
  localparam logic [3:0] MDOP_DIVU  = 4'd4;
  localparam logic [3:0] MDOP_MFHI  = 4'd5;
  localparam logic [3:0] MDOP_MFLO  = 4'd6;
  localparam logic [3:0] MDOP_MTHI  = 4'd7;
  localparam logic [3:0] MDOP_MTLO  = 4'd8;
  localparam logic [3:0] MDOP_MADD  = 4'd9;
  localparam logic [3:0] MDOP_MADDU = 4'd10;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // Ops that launch a multi-cycle operation when qualified by start
  function automatic logic is_start_op(input logic [3:0] op);
    case (op)
      MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MDOP_MADD, MDOP_MADDU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_stage_if.sv
// Execute-stage <-> multiply/divide unit bus: operation request from control,
// busy/HI/LO/mfhi-mflo result back.
interface mdu_stage_if;
  logic        start;
  logic [3:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdres;

  modport master (
    output start, mdop, a, b,
    input  busy, hi, lo, mdres
  );

  modport slave (
    input  start, mdop, a, b,
    output busy, hi, lo, mdres
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Produces the 64-bit {HI,LO} result
// for the op in mdop; divide by zero raises div0 and passes hilo through.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate onto hilo).
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo,
  output logic [63:0] result,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;

  // Signed divide runs on magnitudes so the INT_MIN / -1 case wraps to
  // quotient 0x80000000, remainder 0 without relying on signed overflow.
  always_comb begin
    prod_u = {32'b0, a} * {32'b0, b};
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    div0   = is_div_op(mdop) && (b == '0);

    if (mdop == MDOP_DIV) begin
      ua = a[31] ? (32'd0 - a) : a;
      ub = b[31] ? (32'd0 - b) : b;
    end else begin
      ua = a;
      ub = b;
    end
    if (ub == '0) ub = 32'd1;

    uq = ua / ub;
    ur = ua % ub;
    sq = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
    sr = a[31] ? (32'd0 - ur) : ur;

    case (mdop)
      MDOP_MULT:  result = prod_s;
      MDOP_MULTU: result = prod_u;
      MDOP_DIV:   result = {sr, sq};
      MDOP_DIVU:  result = {ur, uq};
`ifdef MDU_MADD_EN
      MDOP_MADD:  result = hilo + prod_s;
      MDOP_MADDU: result = hilo + prod_u;
`endif
      default:    result = hilo;
    endcase
    if (div0) result = hilo;
  end

endmodule

// File: rtl/mdu_stage.sv
// Execute-stage multiply/divide unit: owns HI/LO, holds the result of a
// launched op in pending registers and commits it after a fixed latency,
// signalling busy meanwhile. MFHI/MFLO are served combinationally on mdres.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU).
module mdu_stage
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  mdu_stage_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, commit, wr_hi, wr_lo;

  logic [31:0]   hi_q, lo_q;
  logic [63:0]   pend_q;
  logic          pend_div0_q;
  logic [63:0]   arith_res;
  logic          arith_div0;

  mdu_arith u_arith (
    .mdop   (bus.mdop),
    .a      (bus.a),
    .b      (bus.b),
    .hilo   ({hi_q, lo_q}),
    .result (arith_res),
    .div0   (arith_div0)
  );

  // FSM and countdown register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and HI/LO write controls
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && is_start_op(bus.mdop)) begin
          accept  = 1'b1;
          state_d = ST_RUN;
          cnt_d   = is_div_op(bus.mdop) ? DIV_LOAD : MULT_LOAD;
        end else if (bus.mdop == MDOP_MTHI) begin
          wr_hi = 1'b1;
        end else if (bus.mdop == MDOP_MTLO) begin
          wr_lo = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(1)) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending result capture and architectural HI/LO updates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q        <= '0;
      lo_q        <= '0;
      pend_q      <= '0;
      pend_div0_q <= 1'b0;
    end else begin
      if (accept) begin
        pend_q      <= arith_res;
        pend_div0_q <= arith_div0;
      end
      if (commit && !pend_div0_q) begin
        hi_q <= pend_q[63:32];
        lo_q <= pend_q[31:0];
      end
      if (wr_hi) hi_q <= bus.a;
      if (wr_lo) lo_q <= bus.a;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // MFHI/MFLO read port
  always_comb begin
    bus.mdres = '0;
    if (bus.mdop == MDOP_MFHI)      bus.mdres = hi_q;
    else if (bus.mdop == MDOP_MFLO) bus.mdres = lo_q;
  end

endmodule

// File: tb/tb_mdu_stage.sv
// Self-checking bench for mdu_stage with a scoreboard of expected {HI,LO}.
// Build with +define+MDU_MADD_EN to exercise MADD/MADDU.
module tb_mdu_stage;
  import mdu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mdu_stage_if bus ();

  mdu_stage #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [63:0] sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.mdop  = MDOP_NOP;
    bus.a     = '0;
    bus.b     = '0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    bus.start = 1'b1;
    bus.mdop  = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    idle_inputs();
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  task automatic mt_write(input logic [3:0] op, input logic [31:0] v);
    bus.mdop = op;
    bus.a    = v;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    #2;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_state busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", bus.busy, bus.hi, bus.lo);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int cyc;
    logic [63:0] exp;
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
    run_op(MDOP_MULT, 32'hFFFFFFFE, 32'd3, cyc);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL mult_busy_cycles got=%0d required=5", cyc);
    end
    exp = sb.pop_front();
    checks++;
    if ({bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL mult_hilo got=%h_%h required=%h", bus.hi, bus.lo, exp);
    end
    bus.mdop = MDOP_MFHI;
    #1;
    checks++;
    if (bus.mdres !== exp[63:32]) begin
      errors++;
      $display("FAIL mfhi got=%h required=%h", bus.mdres, exp[63:32]);
    end
    bus.mdop = MDOP_MFLO;
    #1;
    checks++;
    if (bus.mdres !== exp[31:0]) begin
      errors++;
      $display("FAIL mflo got=%h required=%h", bus.mdres, exp[31:0]);
    end
    bus.mdop = MDOP_NOP;
    #1;
    checks++;
    if (bus.mdres !== 32'h0) begin
      errors++;
      $display("FAIL mdres_nop got=%h required=0", bus.mdres);
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ra, rb;
      longint p;
      ra = $urandom;
      rb = $urandom;
      p  = longint'($signed(ra)) * longint'($signed(rb));
      sb.push_back(64'(p));
      run_op(MDOP_MULT, ra, rb, cyc);
      exp = sb.pop_front();
      checks++;
      if ({bus.hi, bus.lo} !== exp || cyc !== 5) begin
        errors++;
        $display("FAIL mult_rand a=%h b=%h got=%h_%h cyc=%0d required=%h cyc=5", ra, rb, bus.hi, bus.lo, cyc, exp);
      end
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom | 32'h1;
      sb.push_back({ra % rb, ra / rb});
      run_op(MDOP_MULTU, ra, rb, cyc);
      sb.pop_front();
      sb.push_back({32'h0, 32'h0} + 64'({32'h0, ra} * {32'h0, rb}));
      exp = sb.pop_front();
      checks++;
      if ({bus.hi, bus.lo} !== exp) begin
        errors++;
        $display("FAIL multu_rand a=%h b=%h got=%h_%h required=%h", ra, rb, bus.hi, bus.lo, exp);
      end
      sb.push_back({ra % rb, ra / rb});
      run_op(MDOP_DIVU, ra, rb, cyc);
      exp = sb.pop_front();
      checks++;
      if ({bus.hi, bus.lo} !== exp || cyc !== 10) begin
        errors++;
        $display("FAIL divu_rand a=%h b=%h got=%h_%h cyc=%0d required=%h cyc=10", ra, rb, bus.hi, bus.lo, cyc, exp);
      end
    end
  endtask

  task automatic test_div();
    int cyc;
    logic [63:0] exp;
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(MDOP_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    exp = sb.pop_front();
    checks++;
    if (cyc !== 10) begin
      errors++;
      $display("FAIL div_busy_cycles got=%0d required=10", cyc);
    end
    checks++;
    if ({bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL div_signed got=%h_%h required=%h", bus.hi, bus.lo, exp);
    end
    sb.push_back({32'h00000001, 32'h7FFFFFFC});
    run_op(MDOP_DIVU, 32'hFFFFFFF9, 32'd2, cyc);
    exp = sb.pop_front();
    checks++;
    if ({bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL divu got=%h_%h required=%h", bus.hi, bus.lo, exp);
    end
    sb.push_back({32'h00000000, 32'h80000000});
    run_op(MDOP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    exp = sb.pop_front();
    checks++;
    if ({bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL div_overflow got=%h_%h required=%h", bus.hi, bus.lo, exp);
    end
  endtask

  task automatic test_div0();
    int cyc;
    logic [63:0] exp;
    mt_write(MDOP_MTHI, 32'h11);
    checks++;
    if (bus.hi !== 32'h11 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi got hi=%h busy=%b required hi=00000011 busy=0", bus.hi, bus.busy);
    end
    mt_write(MDOP_MTLO, 32'h22);
    checks++;
    if (bus.lo !== 32'h22 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo got lo=%h busy=%b required lo=00000022 busy=0", bus.lo, bus.busy);
    end
    sb.push_back({32'h11, 32'h22});
    run_op(MDOP_DIVU, 32'd5, 32'd0, cyc);
    exp = sb.pop_front();
    checks++;
    if (cyc !== 10) begin
      errors++;
      $display("FAIL div0_busy_cycles got=%0d required=10", cyc);
    end
    checks++;
    if ({bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL div0_hilo got=%h_%h required=%h", bus.hi, bus.lo, exp);
    end
  endtask

  task automatic test_ignored();
    int cyc;
    logic [31:0] old_lo;
    logic [63:0] exp;
    bit bad;
    old_lo = 32'h22;
    sb.push_back({32'h0, 32'd15});
    bus.start = 1'b1;
    bus.mdop  = MDOP_MULT;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    tick();
    bus.mdop = MDOP_MULTU;
    bus.a    = 32'd7;
    bus.b    = 32'd7;
    tick();
    bus.start = 1'b0;
    bus.mdop  = MDOP_MTLO;
    bus.a     = 32'h55;
    tick();
    bus.mdop = MDOP_MFLO;
    #1;
    cyc = 2;
    bad = 1'b0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      if (bus.mdres !== old_lo) bad = 1'b1;
      cyc++;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mflo_during_run got a value other than old lo required=%h", old_lo);
    end
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL ignored_busy_cycles got=%0d required=5", cyc);
    end
    exp = sb.pop_front();
    checks++;
    if ({bus.hi, bus.lo} !== exp || bus.mdres !== exp[31:0]) begin
      errors++;
      $display("FAIL ignored_commit got=%h_%h mdres=%h required=%h", bus.hi, bus.lo, bus.mdres, exp);
    end
    idle_inputs();
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_no_restart busy=%b required=0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [63:0] exp;
    sb.push_back({32'h0, 32'd6});
    sb.push_back({32'h0, 32'd20});
    bus.start = 1'b1;
    bus.mdop  = MDOP_MULTU;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    tick();
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
    exp = sb.pop_front();
    checks++;
    if (cyc !== 5 || {bus.hi, bus.lo} !== exp || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first cyc=%0d busy=%b got=%h_%h required cyc=5 busy=0 %h", cyc, bus.busy, bus.hi, bus.lo, exp);
    end
    bus.a = 32'd4;
    bus.b = 32'd5;
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept busy=%b required=1", bus.busy);
    end
    idle_inputs();
    cyc = 1;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
    cyc--;
    exp = sb.pop_front();
    checks++;
    if (cyc !== 5 || {bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL b2b_second cyc=%0d got=%h_%h required cyc=5 %h", cyc, bus.hi, bus.lo, exp);
    end
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1;
    bus.mdop  = MDOP_DIV;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    sb.push_back({32'd2, 32'd14});
    tick();
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", bus.busy, bus.hi, bus.lo);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (15) tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_no_commit busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_madd();
    int cyc;
    logic [63:0] exp;
    mt_write(MDOP_MTHI, 32'h0);
    mt_write(MDOP_MTLO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    sb.push_back({32'h1, 32'h0});
    run_op(MDOP_MADDU, 32'd1, 32'd1, cyc);
    exp = sb.pop_front();
    checks++;
    if (cyc !== 5 || {bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL maddu cyc=%0d got=%h_%h required cyc=5 %h", cyc, bus.hi, bus.lo, exp);
    end
    sb.push_back({32'h0, 32'hFFFFFFFF});
    run_op(MDOP_MADD, 32'hFFFFFFFF, 32'd1, cyc);
    exp = sb.pop_front();
    checks++;
    if (cyc !== 5 || {bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL madd cyc=%0d got=%h_%h required cyc=5 %h", cyc, bus.hi, bus.lo, exp);
    end
`else
    sb.push_back({32'h0, 32'hFFFFFFFF});
    run_op(MDOP_MADDU, 32'd1, 32'd1, cyc);
    checks++;
    if (cyc !== 0) begin
      errors++;
      $display("FAIL maddu_disabled_busy cyc=%0d required=0", cyc);
    end
    repeat (6) tick();
    exp = sb.pop_front();
    checks++;
    if ({bus.hi, bus.lo} !== exp || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL maddu_disabled_hilo got=%h_%h busy=%b required=%h busy=0", bus.hi, bus.lo, bus.busy, exp);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    test_madd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
